sobel_frame_ctrl: RTL and testbench
===================================

Name: sobel_frame_ctrl

Overview:
- Frame sequencer for the Sobel edge path.
- Counts the incoming pixel stream into row/column positions and drives line-buffer write and prefill control.
- Generates window_valid and border_flag for the Sobel kernel.
- Emits frame/line markers delayed by the downstream pipeline latency so they align with the magnitude output.

Parameters:
IMG_WIDTH, 640, pixels per line (>=4)
IMG_HEIGHT, 480, lines per frame (>=4)
COL_W, 10, column counter width (2**COL_W >= IMG_WIDTH)
ROW_W, 9, row counter width (2**ROW_W >= IMG_HEIGHT)
PIPE_LAT, 2, cycles from window_valid to magnitude output (kernel + edge_mag); >=1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow a new frame to start
pix_valid  in  1  input pixel strobe
pix_sof  in  1  qualifies pix_valid: first pixel of frame
lb_wr_en  out  1  line-buffer write strobe (= accepted pixel)
col_addr  out  COL_W  column of accepted pixel / line-buffer address
row_count  out  ROW_W  row of accepted pixel
prefill_active  out  1  high while rows 0..1 are being stored
window_valid  out  1  3x3 window complete, to sobel_kernel
border_flag  out  1  window touches left border (col<2); downstream forces zero
out_valid  out  1  window_valid delayed PIPE_LAT
out_sof  out  1  first out_valid of frame
out_eol  out  1  last out_valid of a line
out_eof  out  1  last out_valid of frame
frame_done  out  1  one-cycle pulse after last input pixel of frame
sof_err  out  1  one-cycle pulse: pix_sof seen mid-frame

Behaviour:
- Reset (async): state=IDLE, all counters 0, all outputs 0, delay line cleared.
- FSM states:
  - IDLE: wait for enable & pix_valid & pix_sof. That pixel is accepted as (row 0, col 0) -> PREFILL. pix_valid without pix_sof in IDLE is dropped; no output.
  - PREFILL: rows 0..1. prefill_active=1, window_valid=0. Transition to ACTIVE on accepting (row 1, col W-1).
  - ACTIVE: rows 2..H-1. Every accepted pixel asserts window_valid in the same cycle as lb_wr_en (combinational from the accepted pixel). On accepting (H-1, W-1) -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE. Any pixel arriving in DONE is dropped.
- Counters:
  - col_addr/row_count advance only on accepted pixels.
  - Column wraps W-1 -> 0 with row+1.
  - Outputs show the position of the pixel currently accepted.
- border_flag = window_valid & (col_addr < 2).
- Markers, computed at acceptance:
  - sof = first ACTIVE pixel (row 2, col 0)
  - eol = col W-1
  - eof = (H-1, W-1)
  - valid/sof/eol/eof/border pass through a PIPE_LAT-stage shift register to the out_* ports.
  - Out-of-frame bubbles propagate as zeros.
- Mid-frame pix_sof (PREFILL/ACTIVE, with pix_valid):
  - sof_err pulses.
  - Counters restart; the pixel is taken as (0,0); state -> PREFILL.
  - Delay-line contents already in flight are still emitted.
- enable deasserted mid-frame: the current frame completes normally; the next frame does not start until enable=1.
- pix_valid gaps: counters hold; no window_valid.
- Output count per frame: (H-2)*W out_valid pulses, of which 2*(H-2) carry border flag.

Decomposition:
- Shared package sobel_pkg:
  - state encoding (IDLE/PREFILL/ACTIVE/DONE)
  - PIXEL_WIDTH/SOBEL_WIDTH constants
  - PIPE_LAT default
  - marker bundle field order {border, eof, eol, sof, valid}
- Sub-module sobel_marker_delay: parameterised DEPTH x WIDTH shift register with async reset.

Test Plan (W=8, H=6, PIPE_LAT=2):
- Full frame, continuous pix_valid after sof:
  - 48 lb_wr_en; prefill_active for first 16 cycles; 32 window_valid.
  - out_sof exactly 2 cycles after the window_valid for (2,0).
  - out_eof 2 cycles after pixel (5,7); frame_done on the cycle after (5,7).
- Border check: border_flag high at cols 0,1 of rows 2..5 (8 pulses total); out_eol 4 times.
- Gapped input, pix_valid 1-of-3 cycles: same 32 out_valid and marker order; col_addr holds during gaps.
- Mid-frame sof at pixel (3,4):
  - sof_err 1 cycle; next accepted pixel reports (0,1); prefill_active re-asserts.
  - Restarted frame completes with its own out_sof/out_eof.
- Pixels without sof in IDLE (10 cycles): zero lb_wr_en. enable=0 when sof arrives: frame ignored.
- Async reset at pixel (3,2): all outputs 0 immediately, no trailing out_valid. Next sof starts a clean frame at (0,0).

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge path: frame-sequencer state encoding,
// data-path widths, default pipeline latency and the marker bundle that travels
// alongside the window strobe.
package sobel_pkg;

  localparam int unsigned PIXEL_WIDTH  = 8;
  localparam int unsigned SOBEL_WIDTH  = 11;
  localparam int unsigned PIPE_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Field order {border, eof, eol, sof, valid}; valid is bit 0.
  typedef struct packed {
    logic border;
    logic eof;
    logic eol;
    logic sof;
    logic valid;
  } marker_t;

  localparam int unsigned MARKER_W = $bits(marker_t);

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Pixel-stream and control bundle for sobel_frame_ctrl.
//   master: pixel source (enable, pix_valid, pix_sof out; status/markers in)
//   slave : frame controller (the reverse)
interface sobel_frame_ctrl_if #(
  parameter int unsigned COL_W = 10,
  parameter int unsigned ROW_W = 9
);

  logic             enable;
  logic             pix_valid;
  logic             pix_sof;
  logic             lb_wr_en;
  logic [COL_W-1:0] col_addr;
  logic [ROW_W-1:0] row_count;
  logic             prefill_active;
  logic             window_valid;
  logic             border_flag;
  logic             out_valid;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;
  logic             out_border;
  logic             frame_done;
  logic             sof_err;

  modport master (
    output enable, pix_valid, pix_sof,
    input  lb_wr_en, col_addr, row_count, prefill_active, window_valid,
           border_flag, out_valid, out_sof, out_eol, out_eof, out_border,
           frame_done, sof_err
  );

  modport slave (
    input  enable, pix_valid, pix_sof,
    output lb_wr_en, col_addr, row_count, prefill_active, window_valid,
           border_flag, out_valid, out_sof, out_eol, out_eof, out_border,
           frame_done, sof_err
  );

endinterface

// File: rtl/sobel_marker_delay.sv
// DEPTH-stage shift register carrying the marker bundle so it lines up with the
// magnitude output. Bubbles shift through as zeros.
//   clk, rst_n : clock, async active-low reset (clears every stage)
//   din        : bundle entering this cycle
//   dout       : bundle from DEPTH cycles ago
module sobel_marker_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge path. Counts accepted pixels into row/col
// positions, drives line-buffer write/prefill control, produces window_valid and
// border_flag, and delays frame/line markers by PIPE_LAT.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : enable/pix_valid/pix_sof in; lb_wr_en, col_addr, row_count,
//                prefill_active, window_valid, border_flag, out_valid/sof/eol/
//                eof/border, frame_done, sof_err out (all registered)
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned PIPE_LAT   = PIPE_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  sobel_frame_ctrl_if.slave bus
);

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] PRE_LAST   = ROW_W'(1);
  localparam logic [ROW_W-1:0] FIRST_WIN  = ROW_W'(2);
  localparam logic [COL_W-1:0] BORDER_COL = COL_W'(2);

  state_t           state;
  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] nxt_row;
  logic             lb_wr_en;
  logic [COL_W-1:0] col_addr;
  logic [ROW_W-1:0] row_count;
  logic             prefill_active;
  logic             frame_done;
  logic             sof_err;
  marker_t          mark;
  marker_t          mark_dly;

  logic             in_frame_c;
  logic             start_c;
  logic             restart_c;
  logic             accept_c;
  logic [COL_W-1:0] acc_col_c;
  logic [ROW_W-1:0] acc_row_c;
  logic             last_col_c;
  logic             last_pix_c;
  logic             win_c;

  // Decode whether this cycle's pixel is taken and at which position.
  always_comb begin
    in_frame_c = (state == ST_PREFILL) || (state == ST_ACTIVE);
    start_c    = (state == ST_IDLE) && bus.enable && bus.pix_valid && bus.pix_sof;
    restart_c  = in_frame_c && bus.pix_valid && bus.pix_sof;
    accept_c   = start_c || (in_frame_c && bus.pix_valid);
    acc_col_c  = (start_c || restart_c) ? '0 : nxt_col;
    acc_row_c  = (start_c || restart_c) ? '0 : nxt_row;
    last_col_c = (acc_col_c == LAST_COL);
    last_pix_c = last_col_c && (acc_row_c == LAST_ROW);
    // A restart pixel lands on row 0, so it never completes a window.
    win_c      = accept_c && (state == ST_ACTIVE) && !restart_c;
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      nxt_col        <= '0;
      nxt_row        <= '0;
      lb_wr_en       <= 1'b0;
      col_addr       <= '0;
      row_count      <= '0;
      prefill_active <= 1'b0;
      frame_done     <= 1'b0;
      sof_err        <= 1'b0;
      mark           <= '0;
    end else begin
      lb_wr_en       <= accept_c;
      sof_err        <= restart_c;
      frame_done     <= 1'b0;
      // Prefill stays high across input gaps while rows 0..1 are incomplete.
      prefill_active <= accept_c ? !win_c : (state == ST_PREFILL);

      mark.valid  <= win_c;
      mark.sof    <= win_c && (acc_row_c == FIRST_WIN) && (acc_col_c == '0);
      mark.eol    <= win_c && last_col_c;
      mark.eof    <= win_c && last_pix_c;
      mark.border <= win_c && (acc_col_c < BORDER_COL);

      if (accept_c) begin
        col_addr  <= acc_col_c;
        row_count <= acc_row_c;
        if (last_col_c) begin
          nxt_col <= '0;
          nxt_row <= last_pix_c ? '0 : acc_row_c + ROW_W'(1);
        end else begin
          nxt_col <= acc_col_c + COL_W'(1);
          nxt_row <= acc_row_c;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start_c) state <= ST_PREFILL;
        end
        ST_PREFILL: begin
          if (restart_c)                                     state <= ST_PREFILL;
          else if (accept_c && last_col_c && acc_row_c == PRE_LAST) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (restart_c)                   state <= ST_PREFILL;
          else if (accept_c && last_pix_c) state <= ST_DONE;
        end
        ST_DONE: begin
          frame_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sobel_marker_delay #(
    .DEPTH (PIPE_LAT),
    .WIDTH (MARKER_W)
  ) u_marker_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mark),
    .dout  (mark_dly)
  );

  assign bus.lb_wr_en       = lb_wr_en;
  assign bus.col_addr       = col_addr;
  assign bus.row_count      = row_count;
  assign bus.prefill_active = prefill_active;
  assign bus.window_valid   = mark.valid;
  assign bus.border_flag    = mark.border;
  assign bus.out_valid      = mark_dly.valid;
  assign bus.out_sof        = mark_dly.sof;
  assign bus.out_eol        = mark_dly.eol;
  assign bus.out_eof        = mark_dly.eof;
  assign bus.out_border     = mark_dly.border;
  assign bus.frame_done     = frame_done;
  assign bus.sof_err        = sof_err;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed + randomized bench for sobel_frame_ctrl (W=8, H=6, PIPE_LAT=2).
// Reference model tracks the frame as a linear pixel index and keeps a queue of
// marker bundles to produce the delayed outputs.
module tb_sobel_frame_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int LAT  = 2;
  localparam int CW   = 3;
  localparam int RW   = 3;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sobel_frame_ctrl_if #(.COL_W(CW), .ROW_W(RW)) bus ();

  sobel_frame_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .COL_W      (CW),
    .ROW_W      (RW),
    .PIPE_LAT   (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit   m_busy, m_done;
  int   m_next;
  logic e_lb, e_pre, e_win, e_bd, e_serr, e_fd;
  int   e_col, e_row;
  logic [4:0] e_out;
  logic [4:0] hist [$];

  // observed event counts
  int c_lb, c_wv, c_ov, c_bd, c_eol, c_sof, c_eof, c_fd, c_pre;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_next = 0;
    e_lb = 0; e_pre = 0; e_win = 0; e_bd = 0; e_serr = 0; e_fd = 0;
    e_col = 0; e_row = 0; e_out = '0;
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back(5'b0);
  endtask

  task automatic model_step(input bit v, input bit s, input bit e);
    bit acc;
    int p;
    logic [4:0] mk;
    acc = 0; p = 0; mk = '0;
    e_fd = m_done; m_done = 0; e_serr = 0;
    if (m_busy && v) begin
      acc = 1;
      if (s) begin p = 0; e_serr = 1; end
      else p = m_next;
    end else if (!m_busy && !e_fd && v && s && e) begin
      acc = 1; p = 0;
    end
    e_lb = acc;
    if (acc) begin
      e_row  = p / W;
      e_col  = p % W;
      m_next = p + 1;
      m_busy = (p != NPIX - 1);
      m_done = (p == NPIX - 1);
      e_pre  = (e_row < 2);
      if (e_row >= 2)
        mk = {e_col < 2, p == NPIX - 1, e_col == W - 1, p == 2 * W, 1'b1};
    end else begin
      e_pre = m_busy && (m_next < 2 * W);
    end
    e_win = mk[0];
    e_bd  = mk[4];
    hist.push_back(mk);
    e_out = hist.pop_front();
  endtask

  task automatic check(input string tag);
    logic [11:0] o, x;
    logic [4:0]  oo;
    o  = {bus.lb_wr_en, bus.col_addr, bus.row_count, bus.prefill_active,
          bus.window_valid, bus.border_flag, bus.sof_err, bus.frame_done};
    x  = {e_lb, CW'(e_col), RW'(e_row), e_pre, e_win, e_bd, e_serr, e_fd};
    oo = {bus.out_border, bus.out_eof, bus.out_eol, bus.out_sof, bus.out_valid};
    n_vec++;
    assert (o === x) else begin
      n_err++;
      $error("FAIL %s/ctrl t=%0t: observed %h expected %h", tag, $time, o, x);
    end
    n_vec++;
    assert (oo === e_out) else begin
      n_err++;
      $error("FAIL %s/markers t=%0t: observed %b expected %b", tag, $time, oo, e_out);
    end
    c_lb  += int'(bus.lb_wr_en);
    c_wv  += int'(bus.window_valid);
    c_ov  += int'(bus.out_valid);
    c_bd  += int'(bus.out_valid && bus.out_border);
    c_eol += int'(bus.out_eol);
    c_sof += int'(bus.out_sof);
    c_eof += int'(bus.out_eof);
    c_fd  += int'(bus.frame_done);
    c_pre += int'(bus.prefill_active);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    c_lb = 0; c_wv = 0; c_ov = 0; c_bd = 0; c_eol = 0;
    c_sof = 0; c_eof = 0; c_fd = 0; c_pre = 0;
  endtask

  task automatic frame_counts(input string tag, input int lb);
    chk_int({tag, "_lb_wr_en"}, c_lb, lb);
    chk_int({tag, "_window_valid"}, c_wv, (H - 2) * W);
    chk_int({tag, "_out_valid"}, c_ov, (H - 2) * W);
    chk_int({tag, "_out_border"}, c_bd, 2 * (H - 2));
    chk_int({tag, "_out_eol"}, c_eol, H - 2);
    chk_int({tag, "_out_sof"}, c_sof, 1);
    chk_int({tag, "_out_eof"}, c_eof, 1);
    chk_int({tag, "_frame_done"}, c_fd, 1);
  endtask

  task automatic cyc(input bit v, input bit s, input bit e, input string tag);
    @(negedge clk);
    bus.pix_valid = v;
    bus.pix_sof   = s;
    bus.enable    = e;
    @(posedge clk);
    model_step(v, s, e);
    #1;
    check(tag);
  endtask

  // mode 0: back-to-back, 1: one pixel every third cycle, 2: random gaps
  task automatic run_pixels(input int n, input bit first_sof, input int mode,
                            input bit en, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, first_sof && (i == 0), en, tag);
      if (mode == 1) begin
        cyc(1'b0, 1'b0, en, tag);
        cyc(1'b0, 1'b0, en, tag);
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 3)) cyc(1'b0, 1'($urandom_range(0, 1)), en, tag);
      end
    end
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) cyc(1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.pix_valid = 1'b0; bus.pix_sof = 1'b0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1 check("reset");
    @(negedge clk) rst_n = 1'b1;

    // continuous frame
    clear_counts();
    run_pixels(NPIX, 1'b1, 0, 1'b1, "cont");
    idle(4, "cont");
    frame_counts("cont", NPIX);
    chk_int("cont_prefill_cycles", c_pre, 2 * W);

    // one-of-three pixel cadence
    clear_counts();
    run_pixels(NPIX, 1'b1, 1, 1'b1, "gap3");
    idle(4, "gap3");
    frame_counts("gap3", NPIX);

    // pixels without sof in IDLE, then a frame with enable low
    clear_counts();
    repeat (10) cyc(1'b1, 1'b0, 1'b1, "nosof");
    run_pixels(NPIX, 1'b1, 0, 1'b0, "noen");
    idle(3, "noen");
    chk_int("idle_lb_wr_en", c_lb, 0);
    chk_int("idle_out_valid", c_ov, 0);

    // random gaps, enable dropped after the frame starts
    clear_counts();
    run_pixels(1, 1'b1, 0, 1'b1, "rnd");
    run_pixels(NPIX - 1, 1'b0, 2, 1'b0, "rnd");
    idle(4, "rnd");
    frame_counts("rnd", NPIX);
    cyc(1'b1, 1'b1, 1'b0, "rnd_noen");

    // mid-frame sof at pixel (3,4)
    run_pixels(3 * W + 4, 1'b1, 0, 1'b1, "mid");
    run_pixels(1, 1'b1, 0, 1'b1, "mid_sof");
    run_pixels(3, 1'b0, 0, 1'b1, "mid");
    clear_counts();
    run_pixels(NPIX - 4, 1'b0, 0, 1'b1, "mid");
    idle(4, "mid");
    frame_counts("mid", NPIX - 4);

    // async reset at pixel (3,2)
    run_pixels(3 * W + 3, 1'b1, 2, 1'b1, "arst");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("arst_now");
    @(negedge clk) rst_n = 1'b1;
    clear_counts();
    repeat (3) cyc(1'b1, 1'b0, 1'b1, "arst_after");
    chk_int("arst_trailing_out_valid", c_ov, 0);
    clear_counts();
    run_pixels(NPIX, 1'b1, 2, 1'b1, "clean");
    idle(4, "clean");
    frame_counts("clean", NPIX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
